// File: rtl/spi_periph_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_periph_pkg
// Description : Shared constants, field offsets and FSM state type for the
//               SPI register-file peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_periph_pkg;

    // Default frame geometry: rw bit, 7-bit address, 8-bit data
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;
    localparam int FRAME_W    = 1 + DEF_ADDR_W + DEF_DATA_W;
    // Counter must hold FRAME_W+1 so an over-length frame stays visible
    localparam int CNT_W      = $clog2(FRAME_W + 2);

    // Field offsets inside the received frame (MSB first on the wire)
    localparam int RW_BIT     = FRAME_W - 1;
    localparam int ADDR_LSB   = DEF_DATA_W;
    localparam int DATA_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Geometry helpers so a parameter override of the top stays consistent
    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int cnt_width(input int frame_w);
        return $clog2(frame_w + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchroniser for an asynchronous input with
//               single-cycle rise and fall pulses on the synchronised level.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pad value through the synchroniser and keep last level for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_regfile_periph.sv
`default_nettype none
// ============================================================================
// Module      : spi_regfile_periph
// Description : SPI mode-0 peripheral giving the master read/write access to
//               a bank of control registers. All SPI pins are oversampled on
//               clk; write strobes and frame-error pulses for the core side.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_regfile_periph
    import spi_periph_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int FRM_W = frame_width(ADDR_W, DATA_W);
    localparam int CW    = cnt_width(FRM_W);
    localparam int RWB   = FRM_W - 1;
    localparam int ALSB  = DATA_W;

    localparam logic [CW-1:0]     C_CNT_RD   = CW'(ADDR_W);
    localparam logic [CW-1:0]     C_CNT_FULL = CW'(FRM_W);
    localparam logic [CW-1:0]     C_CNT_SAT  = CW'(FRM_W + 1);
    localparam logic [ADDR_W:0]   C_NREGS    = (ADDR_W + 1)'(NUM_REGS);

    // ------------------------------------------------------------------
    // Pad synchronisers
    // ------------------------------------------------------------------
    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic w_copi_s;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (sclk),
        .sync_o  (w_sclk_s),
        .rise_o  (w_sclk_rise),
        .fall_o  (w_sclk_fall)
    );

    // cs_n idles high, so it resets high to avoid a spurious edge
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (cs_n),
        .sync_o  (w_cs_s),
        .rise_o  (w_cs_rise),
        .fall_o  (w_cs_fall)
    );

    // Plain synchroniser for copi; same depth keeps it aligned with sclk edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) copi_sync_q <= '0;
        else        copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
    end
    assign w_copi_s = copi_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CW-1:0]       bit_cnt_q;
    logic [FRM_W-1:0]    rx_q;
    logic [DATA_W-1:0]   tx_q;
    logic                cipo_q;
    logic                pend_q;
    logic [DATA_W-1:0]   reg_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_strobe_q;
    logic                frame_err_q;

    // Receive path decode
    logic [FRM_W-1:0]    w_rx_next;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_c_rw;
    logic [ADDR_W-1:0]   w_c_addr;
    logic [DATA_W-1:0]   w_c_data;
    logic                w_c_full;
    logic                w_c_in_rng;
    logic                w_commit_ok;
    logic                w_commit_err;
    logic                w_start;

    assign w_rx_next  = {rx_q[FRM_W-2:0], w_copi_s};
    assign w_rd_addr  = w_rx_next[ADDR_W-1:0];

    assign w_c_rw     = rx_q[RWB];
    assign w_c_addr   = rx_q[ALSB +: ADDR_W];
    assign w_c_data   = rx_q[DATA_W-1:0];
    assign w_c_full   = (bit_cnt_q == C_CNT_FULL);
    assign w_c_in_rng = ({1'b0, w_c_addr} < C_NREGS);

    assign w_commit_ok  = (state_q == COMMIT) && w_c_full && w_c_rw && w_c_in_rng;
    assign w_commit_err = (state_q == COMMIT) && (!w_c_full || (w_c_rw && !w_c_in_rng));

    // A cs_n fall seen during COMMIT is held in pend_q and started here
    assign w_start = (state_q == IDLE) && (w_cs_fall || pend_q);

    // Read mux: register addressed by the frame so far; 0 for writes or bad address
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!w_rx_next[ADDR_W] && (w_rd_addr == ADDR_W'(i))) w_rd_word = reg_q[i];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: frame opens on cs_n fall, closes on cs_n rise
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_cs_fall || pend_q) state_d = SHIFT;
            SHIFT:   if (w_cs_rise)           state_d = COMMIT;
            COMMIT:                           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Shift datapath: sample copi on sclk rise, drive cipo on sclk fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            cipo_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            pend_q <= (state_q == COMMIT) && w_cs_fall;
            if (w_start) begin
                bit_cnt_q <= '0;
                rx_q      <= '0;
                tx_q      <= '0;
                cipo_q    <= 1'b0;
            end else if (state_q == SHIFT) begin
                // A cs_n rise in the same cycle closes the frame and drops the bit
                if (!w_cs_rise) begin
                    if (w_sclk_rise) begin
                        if (bit_cnt_q != C_CNT_SAT)  bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q < C_CNT_FULL)  rx_q      <= w_rx_next;
                        if (bit_cnt_q == C_CNT_RD)   tx_q      <= w_rd_word;
                    end else if (w_sclk_fall) begin
                        cipo_q <= tx_q[DATA_W-1];
                        tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
            end else begin
                cipo_q <= 1'b0;
            end
        end
    end

    // Register bank update, write strobe and frame error at frame commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_strobe_q <= '0;
            frame_err_q <= w_commit_err;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit_ok && (w_c_addr == ADDR_W'(i))) begin
                    reg_q[i]       <= w_c_data;
                    wr_strobe_q[i] <= 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[gi*DATA_W +: DATA_W] = reg_q[gi];
        end
    endgenerate

    assign cipo      = cipo_q;
    assign cipo_oe   = (state_q == SHIFT);
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;

    // Synchronised sclk/cs_n levels are only consumed through their edge pulses
    logic w_unused;
    assign w_unused = w_sclk_s ^ w_cs_s;

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_periph.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_regfile_periph
// Description : Directed self-checking bench for spi_regfile_periph.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_regfile_periph;

    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int HALF     = 6;   // clk periods per sclk phase
    localparam int GAP      = 12;  // idle clocks after a frame

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic copi = 1'b0;
    logic cipo;
    logic cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    int strobe_cnt [NUM_REGS];
    int err_cnt = 0;

    logic [NUM_REGS*DATA_W-1:0] exp_regs = '0;

    spi_regfile_periph #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_W      (7),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .copi      (copi),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < NUM_REGS; i++) strobe_cnt[i] = 0;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) if (wr_strobe[i]) strobe_cnt[i] = strobe_cnt[i] + 1;
            if (frame_err) err_cnt = err_cnt + 1;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame MSB first; return cipo sampled at each sclk rise
    task automatic spi_frame(input logic [31:0] word, input int nbits, input int gap,
                             output logic [31:0] rdata, output logic oe_ok);
        rdata = '0;
        oe_ok = 1'b1;
        cs_n = 1'b0;
        wait_clks(HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = word[i];
            wait_clks(HALF);
            sclk = 1'b1;
            rdata = {rdata[30:0], cipo};
            if (cipo_oe !== 1'b1) oe_ok = 1'b0;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        wait_clks(HALF);
        cs_n = 1'b1;
        copi = 1'b0;
        wait_clks(gap);
    endtask

    task automatic test_reset();
        wait_clks(3);
        n_cmp++;
        if ({regs_flat, wr_strobe, frame_err, cipo, cipo_oe} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got regs=%h strobe=%b err=%b cipo=%b oe=%b required all 0",
                     regs_flat, wr_strobe, frame_err, cipo, cipo_oe);
        end
    endtask

    task automatic test_write_basic();
        logic [31:0] rd;
        logic oe;
        int s0, e0;
        s0 = strobe_cnt[0]; e0 = err_cnt;
        spi_frame(32'h1234, 16, GAP, rd, oe);
        n_cmp++;
        if (rd[7:0] !== 8'h00) begin
            n_bad++; $display("FAIL read_oob_data: got %h required 00", rd[7:0]);
        end
        spi_frame(32'h8042, 16, GAP, rd, oe);
        exp_regs[0*8 +: 8] = 8'h42;
        n_cmp++;
        if (regs_flat !== exp_regs) begin
            n_bad++; $display("FAIL write_reg0: got %h required %h", regs_flat, exp_regs);
        end
        n_cmp++;
        if (strobe_cnt[0] - s0 !== 1) begin
            n_bad++; $display("FAIL strobe_reg0: got %0d pulses required 1", strobe_cnt[0] - s0);
        end
        n_cmp++;
        if (err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL err_basic: got %0d pulses required 0", err_cnt - e0);
        end
    endtask

    task automatic test_readback();
        logic [31:0] rd;
        logic oe;
        int e0;
        spi_frame(32'h84A5, 16, GAP, rd, oe);
        exp_regs[4*8 +: 8] = 8'hA5;
        n_cmp++;
        if (rd[15:0] !== 16'h0000) begin
            n_bad++; $display("FAIL write_cipo_zero: got %h required 0000", rd[15:0]);
        end
        e0 = err_cnt;
        spi_frame(32'h0400, 16, GAP, rd, oe);
        n_cmp++;
        if (rd[7:0] !== 8'hA5) begin
            n_bad++; $display("FAIL read_reg4: got %h required a5", rd[7:0]);
        end
        n_cmp++;
        if (oe !== 1'b1 || cipo_oe !== 1'b0) begin
            n_bad++; $display("FAIL cipo_oe: got in_frame=%b after=%b required 1/0", oe, cipo_oe);
        end
        n_cmp++;
        if (regs_flat !== exp_regs || err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL read_side_effect: got %h err=%0d required %h err=0",
                              regs_flat, err_cnt - e0, exp_regs);
        end
    endtask

    task automatic test_bad_addr();
        logic [31:0] rd;
        logic oe;
        int e0, s_sum0, s_sum1;
        e0 = err_cnt;
        s_sum0 = 0;
        for (int i = 0; i < NUM_REGS; i++) s_sum0 += strobe_cnt[i];
        spi_frame(32'h8555, 16, GAP, rd, oe);
        s_sum1 = 0;
        for (int i = 0; i < NUM_REGS; i++) s_sum1 += strobe_cnt[i];
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL err_bad_addr: got %0d pulses required 1", err_cnt - e0);
        end
        n_cmp++;
        if (s_sum1 - s_sum0 !== 0 || regs_flat !== exp_regs) begin
            n_bad++; $display("FAIL bad_addr_write: got strobes=%0d regs=%h required 0 and %h",
                              s_sum1 - s_sum0, regs_flat, exp_regs);
        end
    endtask

    task automatic test_length();
        logic [31:0] rd;
        logic oe;
        int e0;
        e0 = err_cnt;
        spi_frame(32'h4008, 15, GAP, rd, oe);
        n_cmp++;
        if (err_cnt - e0 !== 1 || regs_flat !== exp_regs) begin
            n_bad++; $display("FAIL short_frame: got err=%0d regs=%h required 1 and %h",
                              err_cnt - e0, regs_flat, exp_regs);
        end
        e0 = err_cnt;
        spi_frame(32'h10022, 17, GAP, rd, oe);
        n_cmp++;
        if (err_cnt - e0 !== 1 || regs_flat !== exp_regs) begin
            n_bad++; $display("FAIL long_frame: got err=%0d regs=%h required 1 and %h",
                              err_cnt - e0, regs_flat, exp_regs);
        end
        // Chip select with no clocks at all
        e0 = err_cnt;
        spi_frame(32'h0, 0, GAP, rd, oe);
        n_cmp++;
        if (err_cnt - e0 !== 1 || regs_flat !== exp_regs) begin
            n_bad++; $display("FAIL empty_frame: got err=%0d regs=%h required 1 and %h",
                              err_cnt - e0, regs_flat, exp_regs);
        end
        // sclk toggling while deselected must do nothing
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) begin
            copi = 1'b1; sclk = 1'b1; wait_clks(HALF);
            sclk = 1'b0; wait_clks(HALF);
        end
        copi = 1'b0;
        wait_clks(GAP);
        n_cmp++;
        if (err_cnt - e0 !== 0 || regs_flat !== exp_regs || cipo_oe !== 1'b0) begin
            n_bad++; $display("FAIL idle_sclk: got err=%0d regs=%h oe=%b required 0, %h, 0",
                              err_cnt - e0, regs_flat, exp_regs, cipo_oe);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic oe;
        logic [15:0] w;
        int s1;
        w = 16'h81FF;
        cs_n = 1'b0;
        wait_clks(HALF);
        for (int i = 15; i >= 7; i--) begin
            copi = w[i]; wait_clks(HALF);
            sclk = 1'b1; wait_clks(HALF);
            sclk = 1'b0;
        end
        wait_clks(2);
        rst_n = 1'b0;
        wait_clks(2);
        n_cmp++;
        if ({regs_flat, wr_strobe, frame_err, cipo, cipo_oe} !== '0) begin
            n_bad++;
            $display("FAIL reset_midframe: got regs=%h strobe=%b err=%b cipo=%b oe=%b required all 0",
                     regs_flat, wr_strobe, frame_err, cipo, cipo_oe);
        end
        cs_n = 1'b1; copi = 1'b0; sclk = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(GAP);
        exp_regs = '0;
        s1 = strobe_cnt[1];
        spi_frame(32'h81FF, 16, GAP, rd, oe);
        exp_regs[1*8 +: 8] = 8'hFF;
        n_cmp++;
        if (regs_flat !== exp_regs || strobe_cnt[1] - s1 !== 1) begin
            n_bad++; $display("FAIL after_reset_write: got %h strobes=%0d required %h and 1",
                              regs_flat, strobe_cnt[1] - s1, exp_regs);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic oe;
        int s2, s3, e0;
        s2 = strobe_cnt[2]; s3 = strobe_cnt[3]; e0 = err_cnt;
        spi_frame(32'h8211, 16, 4, rd, oe);
        spi_frame(32'h8322, 16, GAP, rd, oe);
        exp_regs[2*8 +: 8] = 8'h11;
        exp_regs[3*8 +: 8] = 8'h22;
        n_cmp++;
        if (regs_flat !== exp_regs) begin
            n_bad++; $display("FAIL b2b_regs: got %h required %h", regs_flat, exp_regs);
        end
        n_cmp++;
        if (strobe_cnt[2] - s2 !== 1 || strobe_cnt[3] - s3 !== 1) begin
            n_bad++; $display("FAIL b2b_strobes: got %0d/%0d required 1/1",
                              strobe_cnt[2] - s2, strobe_cnt[3] - s3);
        end
        n_cmp++;
        if (err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL b2b_err: got %0d required 0", err_cnt - e0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wait_clks(4);
        test_reset();
        rst_n = 1'b1;
        wait_clks(GAP);
        test_write_basic();
        test_readback();
        test_bad_addr();
        test_length();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
